aes_job_arbiter: RTL and testbench

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

---
 rtl/aes_arb_pkg.sv | 31 +++
 rtl/aes_rr_arb2.sv | 38 +++
 rtl/aes_job_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and constants for the AES job arbiter slice.
package aes_arb_pkg;

  // Job sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Operation codes carried on req_mode
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Default RUN watchdog length in cycles (legal range 1..65535)
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  // One-hot requester vector for a requester id
  function automatic logic [1:0] id_onehot(input logic id);
    logic [1:0] v;
    v = 2'b00;
    if (id) begin
      v = 2'b10;
    end else begin
      v = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: two-way round-robin grant with a "last served" pointer.
// A lone requester always wins; on a tie the requester not served last wins.
module aes_rr_arb2
  import aes_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_served,
  input  logic       i_served_id,
  output logic [1:0] o_grant
);

  logic r_last;

  // Remember the last served requester; reset value makes requester 0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_served) begin
      r_last <= i_served_id;
    end else begin
      r_last <= r_last;
    end
  end

  // Grant decode from the live requests and the last-served pointer
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = id_onehot(~r_last);
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one SPI-attached AES core between two job requesters.
// Flow per job: IDLE (accept) -> LOAD (one cycle, selects low) -> RUN (cs held
// until core_done) -> RESP (one-cycle rsp_valid pulse) -> IDLE.
// Build macro AES_ARB_TIMEOUT_EN adds a RUN watchdog: after TIMEOUT_CYCLES RUN
// cycles without core_done the job ends with rsp_err=1 and rsp_data=0.
// Without the macro rsp_err is tied low and RUN waits indefinitely.
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NB             = 4,
  parameter int NK             = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_mode,
  input  logic [2*32*NB-1:0]  req_msg,
  input  logic [2*32*NK-1:0]  req_key,
  output logic [1:0]          rsp_valid,
  output logic [32*NB-1:0]    rsp_data,
  output logic                rsp_err,
  output logic [32*NB-1:0]    core_msg,
  output logic [32*NK-1:0]    core_key,
  output logic                cs_enc,
  output logic                cs_dec,
  input  logic                core_done,
  input  logic [32*NB-1:0]    core_result
);

  localparam int MW = 32 * NB;
  localparam int KW = 32 * NK;

  arb_state_e    r_state;
  logic [1:0]    r_rsp_valid;
  logic [MW-1:0] r_rsp_data;
  logic [MW-1:0] r_core_msg;
  logic [KW-1:0] r_core_key;
  logic          r_cs_enc;
  logic          r_cs_dec;
  logic          r_mode;
  logic          r_id;

  logic [1:0]    w_grant;
  logic [1:0]    w_ready;
  logic          w_accept;
  logic          w_accept_id;
  logic          w_timeout;
  logic [MW-1:0] w_msg_sel;
  logic [KW-1:0] w_key_sel;
  logic          w_mode_sel;

  aes_rr_arb2 u_rr_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req_valid),
    .i_served    (w_accept),
    .i_served_id (w_accept_id),
    .o_grant     (w_grant)
  );

  // Offer the grant only while idle and out of reset; ready tracks the live
  // request pattern so the tie-break always sees the requests present at accept
  always_comb begin
    w_ready = 2'b00;
    if ((r_state == ST_IDLE) && !rst) begin
      w_ready = w_grant;
    end else begin
      w_ready = 2'b00;
    end
  end

  assign req_ready   = w_ready;
  assign w_accept    = |(req_valid & w_ready);
  assign w_accept_id = w_ready[1];

  // Pick the accepted requester's message, key and mode slices
  always_comb begin
    w_msg_sel  = req_msg[MW-1:0];
    w_key_sel  = req_key[KW-1:0];
    w_mode_sel = req_mode[0];
    if (w_accept_id) begin
      w_msg_sel  = req_msg[2*MW-1:MW];
      w_key_sel  = req_key[2*KW-1:KW];
      w_mode_sel = req_mode[1];
    end else begin
      w_msg_sel  = req_msg[MW-1:0];
      w_key_sel  = req_key[KW-1:0];
      w_mode_sel = req_mode[0];
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        r_rsp_err;

  // Count cycles spent in RUN; held at zero everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 16'd0;
    end else if (r_state == ST_RUN) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end else begin
      r_to_cnt <= 16'd0;
    end
  end

  // Error flag for a watchdog expiry; a same-cycle core_done counts as success
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_rsp_err <= w_timeout && !core_done;
    end else begin
      r_rsp_err <= 1'b0;
    end
  end

  assign w_timeout = (r_state == ST_RUN) && (r_to_cnt == TO_LAST);
  assign rsp_err   = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // Job sequencing FSM; all job-side outputs are registers written here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= {MW{1'b0}};
      r_core_msg  <= {MW{1'b0}};
      r_core_key  <= {KW{1'b0}};
      r_cs_enc    <= 1'b0;
      r_cs_dec    <= 1'b0;
      r_mode      <= 1'b0;
      r_id        <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_core_msg <= w_msg_sel;
            r_core_key <= w_key_sel;
            r_mode     <= w_mode_sel;
            r_id       <= w_accept_id;
            r_state    <= ST_LOAD;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_cs_enc <= (r_mode == MODE_ENC);
          r_cs_dec <= (r_mode == MODE_DEC);
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          if (core_done) begin
            r_rsp_data  <= core_result;
            r_rsp_valid <= id_onehot(r_id);
            r_cs_enc    <= 1'b0;
            r_cs_dec    <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_data  <= {MW{1'b0}};
            r_rsp_valid <= id_onehot(r_id);
            r_cs_enc    <= 1'b0;
            r_cs_dec    <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_state     <= ST_RUN;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_cs_enc <= 1'b0;
          r_cs_dec <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign core_msg  = r_core_msg;
  assign core_key  = r_core_key;
  assign cs_enc    = r_cs_enc;
  assign cs_dec    = r_cs_dec;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: table-driven jobs, hand sequences for reset, tie-break,
// idle core_done and watchdog, then randomized jobs against a transaction model.
module tb_aes_job_arbiter;

  localparam int NB = 4;
  localparam int NK = 4;
  localparam int TO = 16;
  localparam int MW = 32 * NB;
  localparam int KW = 32 * NK;

  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_mode;
  logic [2*MW-1:0]  req_msg;
  logic [2*KW-1:0]  req_key;
  logic [1:0]       rsp_valid;
  logic [MW-1:0]    rsp_data;
  logic             rsp_err;
  logic [MW-1:0]    core_msg;
  logic [KW-1:0]    core_key;
  logic             cs_enc;
  logic             cs_dec;
  logic             core_done;
  logic [MW-1:0]    core_result;

  logic [127:0]     tb_msg [2];
  logic [127:0]     tb_key [2];
  int               n_run  = 0;
  int               n_fail = 0;
  logic             last_served;
  logic             exp_id;
  logic             exp_seq [4];
  logic [127:0]     res;

  typedef struct {
    logic         id;
    logic         mode;
    logic [127:0] msg;
    logic [127:0] key;
    logic [127:0] result;
    int           delay;
    logic [1:0]   exp_cs;   // {cs_enc, cs_dec} during RUN
    logic [1:0]   exp_rv;   // rsp_valid pulse
  } vec_t;
  vec_t vecs [4];

  assign req_msg = {tb_msg[1], tb_msg[0]};
  assign req_key = {tb_key[1], tb_key[0]};

  aes_job_arbiter #(.NB(NB), .NK(NK), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_msg     (req_msg),
    .req_key     (req_key),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .core_msg    (core_msg),
    .core_key    (core_key),
    .cs_enc      (cs_enc),
    .cs_dec      (cs_dec),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic raise(input int r);
    tb_msg[r]    = rand128();
    tb_key[r]    = rand128();
    req_mode[r]  = 1'($urandom_range(1, 0));
    req_valid[r] = 1'b1;
  endtask

  // Reset for two edges, check every output is zero while rst is high
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    core_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    check("rst_rsp_err", 128'(rsp_err), 128'd0);
    check("rst_core_msg", core_msg, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_cs", 128'({cs_enc, cs_dec}), 128'd0);
    rst = 1'b0;
    last_served = 1'b1;
  endtask

  // Called at a negedge in IDLE with requests already driven. Expects a grant to
  // exp_id, one LOAD cycle, RUN for delay+1 cycles, then a one-cycle response.
  task automatic serve(input logic id, input logic [1:0] exp_cs, input logic [1:0] exp_rv,
                       input logic [127:0] result, input int delay);
    int k;
    logic [127:0] m;
    logic [127:0] kk;
    m = tb_msg[id];
    kk = tb_key[id];
    k = 0;
    #1;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("grant", 128'(req_ready), id ? 128'd2 : 128'd1);
    if (req_ready == 2'b00) return;
    @(negedge clk);
    check("load_ready", 128'(req_ready), 128'd0);
    check("load_cs", 128'({cs_enc, cs_dec}), 128'd0);
    check("load_core_msg", core_msg, m);
    check("load_core_key", core_key, kk);
    @(negedge clk);
    check("run_cs", 128'({cs_enc, cs_dec}), 128'(exp_cs));
    check("run_core_msg", core_msg, m);
    check("run_core_key", core_key, kk);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_cs", 128'({cs_enc, cs_dec}), 128'(exp_cs));
      check("wait_rsp_valid", 128'(rsp_valid), 128'd0);
    end
    core_done = 1'b1;
    core_result = result;
    @(negedge clk);
    core_done = 1'b0;
    core_result = rand128();
    check("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
    check("rsp_data", rsp_data, result);
    check("rsp_err", 128'(rsp_err), 128'd0);
    check("rsp_cs", 128'({cs_enc, cs_dec}), 128'd0);
    check("rsp_ready", 128'(req_ready), 128'd0);
    @(negedge clk);
    check("post_rsp_valid", 128'(rsp_valid), 128'd0);
    check("post_rsp_data", rsp_data, result);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_mode = 2'b00;
    core_done = 1'b0;
    core_result = 128'd0;
    tb_msg[0] = 128'd0; tb_msg[1] = 128'd0;
    tb_key[0] = 128'd0; tb_key[1] = 128'd0;
    last_served = 1'b1;

    vecs[0] = '{1'b0, 1'b0, AES_PT, AES_KEY, AES_CT, 0, 2'b10, 2'b01};
    vecs[1] = '{1'b1, 1'b1, AES_CT, AES_KEY, AES_PT, 3, 2'b01, 2'b10};
    vecs[2] = '{1'b0, 1'b1, 128'hdeadbeef_01234567_89abcdef_cafef00d,
                128'h0f0e0d0c_0b0a0908_07060504_03020100,
                128'h13579bdf_2468ace0_fedcba98_76543210, 1, 2'b01, 2'b01};
    vecs[3] = '{1'b1, 1'b0, 128'h11111111_22222222_33333333_44444444,
                128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c,
                128'h0badc0de_feedface_8badf00d_facefeed, 5, 2'b10, 2'b10};
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;

    // Reset state
    do_reset();

    // Table-driven single-requester jobs (includes the AES known-answer pair)
    for (int i = 0; i < 4; i++) begin
      tb_msg[vecs[i].id]    = vecs[i].msg;
      tb_key[vecs[i].id]    = vecs[i].key;
      req_mode[vecs[i].id]  = vecs[i].mode;
      req_valid[vecs[i].id] = 1'b1;
      serve(vecs[i].id, vecs[i].exp_cs, vecs[i].exp_rv, vecs[i].result, vecs[i].delay);
      req_valid[vecs[i].id] = 1'b0;
    end

    // core_done while idle is ignored
    core_done = 1'b1;
    core_result = rand128();
    @(negedge clk);
    core_done = 1'b0;
    check("idle_done_rsp_valid", 128'(rsp_valid), 128'd0);
    check("idle_done_rsp_data", rsp_data, vecs[3].result);
    check("idle_done_cs", 128'({cs_enc, cs_dec}), 128'd0);
    @(negedge clk);
    check("idle_done_rsp_valid2", 128'(rsp_valid), 128'd0);
    tb_msg[0] = rand128(); tb_key[0] = rand128(); req_mode[0] = 1'b0; req_valid[0] = 1'b1;
    serve(1'b0, 2'b10, 2'b01, rand128(), 0);
    req_valid = 2'b00;

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1
    do_reset();
    tb_msg[0] = rand128(); tb_key[0] = rand128(); req_mode[0] = 1'b0;
    tb_msg[1] = rand128(); tb_key[1] = rand128(); req_mode[1] = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(exp_seq[i], exp_seq[i] ? 2'b01 : 2'b10, exp_seq[i] ? 2'b10 : 2'b01, rand128(), i);
    end
    req_valid = 2'b00;

    // Reset pulsed during RUN aborts the job and restores the tie-break
    do_reset();
    tb_msg[0] = rand128(); tb_key[0] = rand128(); req_mode[0] = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("abort_run_cs", 128'({cs_enc, cs_dec}), 128'd2);
    rst = 1'b1;
    tb_msg[1] = rand128(); tb_key[1] = rand128(); req_mode[1] = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    check("abort_cs", 128'({cs_enc, cs_dec}), 128'd0);
    check("abort_rsp_valid", 128'(rsp_valid), 128'd0);
    check("abort_ready", 128'(req_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("abort_tie_ready", 128'(req_ready), 128'd1);
    check("abort_rsp_valid2", 128'(rsp_valid), 128'd0);
    serve(1'b0, 2'b10, 2'b01, rand128(), 2);
    req_valid[0] = 1'b0;
    serve(1'b1, 2'b01, 2'b10, rand128(), 0);
    req_valid = 2'b00;

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog expiry: RUN lasts exactly TO cycles, then an error response
    tb_msg[1] = rand128(); tb_key[1] = rand128(); req_mode[1] = 1'b1;
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("to_run_cs", 128'({cs_enc, cs_dec}), 128'd1);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("to_wait_rsp_valid", 128'(rsp_valid), 128'd0);
      check("to_wait_cs", 128'({cs_enc, cs_dec}), 128'd1);
    end
    @(negedge clk);
    check("to_rsp_valid", 128'(rsp_valid), 128'd2);
    check("to_rsp_err", 128'(rsp_err), 128'd1);
    check("to_rsp_data", rsp_data, 128'd0);
    check("to_cs", 128'({cs_enc, cs_dec}), 128'd0);
    req_valid = 2'b00;
    @(negedge clk);
    check("to_post_rsp_valid", 128'(rsp_valid), 128'd0);
    // core_done on the expiry cycle is a normal completion
    tb_msg[0] = rand128(); tb_key[0] = rand128(); req_mode[0] = 1'b0;
    req_valid = 2'b01;
    serve(1'b0, 2'b10, 2'b01, rand128(), TO - 1);
    req_valid = 2'b00;
`else
    // Without the watchdog RUN waits well past TIMEOUT_CYCLES
    tb_msg[1] = rand128(); tb_key[1] = rand128(); req_mode[1] = 1'b1;
    req_valid = 2'b10;
    serve(1'b1, 2'b01, 2'b10, rand128(), 3 * TO);
    req_valid = 2'b00;
`endif

    // Randomized jobs against a transaction-level round-robin model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if (req_valid == 2'b00 && $urandom_range(3, 0) == 0) begin
        #1;
        check("idle_no_req_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
      end
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && $urandom_range(1, 0) == 1) raise(r);
      end
      if (req_valid == 2'b00) raise(int'($urandom_range(1, 0)));
      if (req_valid == 2'b11) begin
        exp_id = ~last_served;
      end else begin
        exp_id = req_valid[1];
      end
      res = rand128();
      serve(exp_id, req_mode[exp_id] ? 2'b01 : 2'b10, exp_id ? 2'b10 : 2'b01,
            res, int'($urandom_range(4, 0)));
      req_valid[exp_id] = 1'b0;
      last_served = exp_id;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
